rom_burst_reader: RTL

// - Parametrised ROM-to-register-bank loader; successor to the fixed 32x8 ROM reader.
// - Streams DEPTH words from a synchronous ROM (configurable read latency) into a register bank,

---
 rtl/rom_burst_reader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: streams DEPTH words from a synchronous ROM with
// ROM_LATENCY cycles of read latency into a register bank that is exposed in
// parallel on data_flat. Each captured word is also announced with a
// registered one-cycle wr_valid/wr_index/wr_data strobe.
//
// Optional feature: define ROM_READER_CHECKSUM_EN to add a checksum output.
// It holds the XOR of every word captured in the current burst. It is cleared
// when the burst starts and is stable while done is high.
//
// Handshake: start is a level-sampled request. It is accepted only in IDLE or
// DONE, on a rising clock edge where start=1. busy covers the whole burst
// (READ + DRAIN). done stays high until the next accepted start or reset.
// wr_valid is a single-cycle strobe with no back-pressure. wr_index and
// wr_data are meaningful only in the cycle where wr_valid=1.
//
// The current FSM state is held in the 'state' signal (type state_t) for
// checkers bound to this module.

module rom_burst_reader #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int BASE_ADDR   = 0,
  parameter int ROM_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [ADDR_W-1:0]         rom_address,
  output logic                      rom_rd_en,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_W*DEPTH-1:0]   data_flat,
  output logic                      wr_valid,
  output logic [$clog2(DEPTH)-1:0]  wr_index,
  output logic [DATA_W-1:0]         wr_data
`ifdef ROM_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]         checksum
`else
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Index of the word currently being addressed. It stops at DEPTH-1, so it
  // never wraps inside a burst.
  logic [IDX_W-1:0] rd_cnt;

  // Read-tracking pipeline, ROM_LATENCY stages deep. The last stage lines up
  // with the ROM data for the address issued ROM_LATENCY cycles earlier.
  logic [ROM_LATENCY-1:0] vld_pipe;
  logic [IDX_W-1:0]       idx_pipe [ROM_LATENCY];

  logic             cap_valid;
  logic [IDX_W-1:0] cap_idx;
  logic             start_ok;
  logic             last_issue;
  logic             last_capture;

  assign cap_valid    = vld_pipe[ROM_LATENCY-1];
  assign cap_idx      = idx_pipe[ROM_LATENCY-1];
  assign start_ok     = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_issue   = (rd_cnt == IDX_W'(DEPTH - 1));
  assign last_capture = cap_valid && (cap_idx == IDX_W'(DEPTH - 1));
  assign rom_address  = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_cnt);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: issue all addresses, wait for the pipeline, then park
  // in DONE
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start)        state_next = S_READ;
      S_READ:  if (last_issue)   state_next = S_DRAIN;
      S_DRAIN: if (last_capture) state_next = S_DONE;
      S_DONE:  if (start)        state_next = S_READ;
      default:                   state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    rom_rd_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_READ: begin
        rom_rd_en = 1'b1;
        busy      = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Address counter: restarts at 0 on an accepted start, advances through
  // READ, then holds the last address through DRAIN and DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
    end else if (start_ok) begin
      rd_cnt <= '0;
    end else if ((state == S_READ) && !last_issue) begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // Valid/index pipeline tracking each issued read until its data returns.
  // Reset flushes it, so in-flight ROM data is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        idx_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= rom_rd_en;
      idx_pipe[0] <= rd_cnt;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  // Capture returning ROM data into the bank and the one-cycle write strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      data_flat <= '0;
      wr_valid  <= 1'b0;
      wr_index  <= '0;
      wr_data   <= '0;
    end else begin
      wr_valid <= cap_valid;
      if (cap_valid) begin
        data_flat[int'(cap_idx)*DATA_W +: DATA_W] <= rom_q;
        wr_index <= cap_idx;
        wr_data  <= rom_q;
      end
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  // Running XOR of the words captured in the current burst
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (cap_valid) begin
      checksum <= checksum ^ rom_q;
    end
  end
`else
  // Checksum feature disabled: no checksum port or logic in this build.
`endif

endmodule
